// File: rtl/rfid_cmd_if.sv
`timescale 1ns/1ps
// rfid_cmd_if: command handshake to the encoder and decoded tag reply strobe
interface rfid_cmd_if;
  logic       cmd_req;
  logic [2:0] cmd_type;
  logic       cmd_ack;
  logic       rx_valid;
  logic       rx_crc_ok;
  modport master (output cmd_req, cmd_type, input cmd_ack, rx_valid, rx_crc_ok);
  modport slave (input cmd_req, cmd_type, output cmd_ack, rx_valid, rx_crc_ok);
endinterface

// File: rtl/rfid_inventory_sequencer.sv
`timescale 1ns/1ps
// rfid_inventory_sequencer: SORT/QUERY/ACK/READ/WRITE inventory round with retry, done/err and phase LEDs
module rfid_inventory_sequencer #(
  parameter int TIMEOUT_CYC = 2000,
  parameter int TO_W = 16,
  parameter int MAX_RETRY = 3
) (
  input  logic       clk_10m,
  input  logic       rst_p,
  input  logic       start,
  input  logic       abort,
  rfid_cmd_if.master cmd,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] retry_cnt,
  output logic       led_sort,
  output logic       led_query,
  output logic       led_ack,
  output logic       led_read,
  output logic       led_write,
  output logic       led_done
);
  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;
  localparam logic [2:0] SORT = 3'd0, QUERY = 3'd1, WRITE = 3'd4;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [2:0] RETRY_LIM = 3'(MAX_RETRY);
  state_t state;
  logic [2:0] ph;
  logic [TO_W-1:0] timer;
  logic cmd_req;
  logic [2:0] retry_nxt;
  assign retry_nxt = {1'b0, retry_cnt} + 3'd1;
  assign cmd.cmd_req = cmd_req;
  assign cmd.cmd_type = ph;
  assign {led_write, led_read, led_ack, led_query, led_sort} = (state == SEND || state == WAIT) ? 5'b1 << ph : 5'b0;
  assign led_done = done;
  // abort shares the reset path so it beats start, cmd_ack and rx_valid
  always_ff @(posedge clk_10m) begin
    if (rst_p || abort) begin
      state <= IDLE;
      ph <= SORT;
      timer <= '0;
      cmd_req <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      retry_cnt <= 2'd0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state <= SEND;
          ph <= SORT;
          cmd_req <= 1'b1;
          busy <= 1'b1;
          done <= 1'b0;
          err <= 1'b0;
          retry_cnt <= 2'd0;
        end
        // entering SEND with cmd_req low gives one idle cycle between commands
        SEND: if (cmd_req && cmd.cmd_ack) begin
          cmd_req <= 1'b0;
          timer <= '0;
          if (ph == SORT) ph <= QUERY;
          else state <= WAIT;
        end else cmd_req <= 1'b1;
        WAIT: if (cmd.rx_valid && cmd.rx_crc_ok) begin
          if (ph == WRITE) begin
            state <= DONE;
            ph <= SORT;
            busy <= 1'b0;
            done <= 1'b1;
            err <= 1'b0;
          end else begin
            state <= SEND;
            ph <= ph + 3'd1;
          end
        end else if (cmd.rx_valid || timer == TO_LAST) begin
          if (retry_nxt >= RETRY_LIM) begin
            state <= DONE;
            ph <= SORT;
            busy <= 1'b0;
            done <= 1'b1;
            err <= 1'b1;
            retry_cnt <= RETRY_LIM[1:0];
          end else begin
            state <= SEND;
            ph <= QUERY;
            retry_cnt <= retry_nxt[1:0];
          end
        end else timer <= timer + 1'b1;
      endcase
    end
  end
endmodule

// File: tb/tb_rfid_inventory_sequencer.sv
`timescale 1ns/1ps
// tb_rfid_inventory_sequencer: scoreboard bench; a round-level model predicts command and done events
module tb_rfid_inventory_sequencer;
  typedef struct {int kind; int d;} oc_t;
  typedef struct {int a; int r; int lat;} ev_t;
  logic clk_10m = 0, rst_p = 1, start = 0, abort = 0;
  logic busy, done, err, led_sort, led_query, led_ack, led_read, led_write, led_done;
  logic [1:0] retry_cnt;
  rfid_cmd_if cif();
  rfid_inventory_sequencer dut (
    .clk_10m(clk_10m), .rst_p(rst_p), .start(start), .abort(abort), .cmd(cif),
    .busy(busy), .done(done), .err(err), .retry_cnt(retry_cnt),
    .led_sort(led_sort), .led_query(led_query), .led_ack(led_ack),
    .led_read(led_read), .led_write(led_write), .led_done(led_done)
  );
  always #50 clk_10m = ~clk_10m;
  int cyc = 0;
  always @(posedge clk_10m) cyc <= cyc + 1;
  int checks = 0, errors = 0, ref_edge = 0, ack_dly = 3;
  bit auto_rsp = 1;
  oc_t outq[$];
  ev_t cq[$], dq[$];
  wire [4:0] leds = {led_write, led_read, led_ack, led_query, led_sort};
  wire [17:0] all_out = {cif.cmd_req, cif.cmd_type, busy, done, err, retry_cnt, leds, led_done, 2'b00};

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, a, e, cyc);
    end
  endtask

  // Reply kinds: 0 good, 1 bad CRC, 2 no reply. d = edges after WAIT entry when rx_valid is sampled.
  function automatic oc_t gen(input int mode, input int p, input int r);
    int x;
    case (mode)
      0: return '{0, 50};
      1: return (p == 1) ? '{2, 0} : '{0, 50};
      2: return (p == 3 && r == 0) ? '{1, 50} : '{0, 50};
      3: return (p == 1) ? '{0, 2000} : '{0, 50};
      default: begin
        x = $urandom_range(0, 99);
        if (x < 2) return '{2, 0};
        if (x < 12) return '{1, $urandom_range(1, 60)};
        if (x < 14) return '{0, 2000};
        return '{0, $urandom_range(1, 80)};
      end
    endcase
  endfunction

  task automatic pulse_start();
    start = 1;
    ref_edge = cyc;
    @(negedge clk_10m);
    start = 0;
  endtask

  task automatic run_round(input int mode);
    oc_t o;
    int p = 1, r = 0, lat = 2, k = 0;
    bit fin = 0;
    cq.push_back('{0, 0, 1});
    while (!fin) begin
      cq.push_back('{p, r, lat});
      o = gen(mode, p, r);
      outq.push_back(o);
      if (o.kind == 0) begin
        if (p == 4) begin dq.push_back('{0, r, o.d + 1}); fin = 1; end
        else begin p++; lat = o.d + 2; end
      end else begin
        r++;
        if (r >= 3) begin dq.push_back('{1, 3, (o.kind == 2) ? 2001 : o.d + 1}); fin = 1; end
        else begin p = 1; lat = (o.kind == 2) ? 2002 : o.d + 2; end
      end
    end
    pulse_start();
    while ((cq.size() != 0 || dq.size() != 0) && k < 20000) begin @(negedge clk_10m); k++; end
    chk("round_complete", int'(k < 20000), 1);
    repeat (3) @(negedge clk_10m);
  endtask

  // encoder + tag responder
  initial begin
    int t;
    oc_t o;
    forever begin
      @(negedge clk_10m);
      if (auto_rsp && cif.cmd_req && !rst_p) begin
        t = cif.cmd_type;
        repeat (ack_dly - 1) @(negedge clk_10m);
        cif.cmd_ack = 1;
        ref_edge = cyc;
        @(negedge clk_10m);
        cif.cmd_ack = 0;
        if (t != 0) begin
          o = (outq.size() != 0) ? outq.pop_front() : '{2, 0};
          if (o.kind != 2) begin
            repeat (o.d - 1) @(negedge clk_10m);
            cif.rx_valid = 1;
            cif.rx_crc_ok = (o.kind == 0);
            @(negedge clk_10m);
            cif.rx_valid = 0;
            cif.rx_crc_ok = 0;
          end
        end
      end
    end
  end

  // monitor: compares each command issue and each done edge against the scoreboard
  initial begin
    bit prev_req = 0, prev_done = 0;
    ev_t e;
    forever begin
      @(negedge clk_10m);
      if (cif.cmd_req && !prev_req) begin
        if (cq.size() == 0) chk("unexpected_cmd", 1, 0);
        else begin
          e = cq.pop_front();
          chk("cmd_type", cif.cmd_type, e.a);
          chk("cmd_retry_cnt", retry_cnt, e.r);
          chk("cmd_latency", cyc - ref_edge, e.lat);
          chk("cmd_leds", leds, 1 << e.a);
          chk("cmd_busy", busy, 1);
        end
      end
      if (done && !prev_done) begin
        if (dq.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = dq.pop_front();
          chk("done_err", err, e.a);
          chk("done_retry_cnt", retry_cnt, e.r);
          chk("done_latency", cyc - ref_edge, e.lat);
          chk("led_done", led_done, 1);
          chk("done_busy", busy, 0);
          chk("done_leds", leds, 0);
        end
      end
      prev_req = cif.cmd_req;
      prev_done = done;
    end
  end

  initial begin
    #9ms;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    cif.cmd_ack = 0;
    cif.rx_valid = 0;
    cif.rx_crc_ok = 0;
    repeat (3) @(negedge clk_10m);
    rst_p = 0;
    @(negedge clk_10m);
    chk("reset_outputs", all_out, 0);
    run_round(0);
    run_round(1);
    run_round(2);
    run_round(3);
    // abort in WAIT(ACK) together with start
    cq.push_back('{0, 0, 1});
    cq.push_back('{1, 0, 2});
    cq.push_back('{2, 0, 22});
    outq.push_back('{0, 20});
    outq.push_back('{2, 0});
    pulse_start();
    k = 0;
    while (!(led_ack && cif.cmd_req) && k < 1000) begin @(negedge clk_10m); k++; end
    while (cif.cmd_req && k < 1000) begin @(negedge clk_10m); k++; end
    chk("reach_wait_ack", int'(k < 1000), 1);
    repeat (5) @(negedge clk_10m);
    abort = 1;
    start = 1;
    @(negedge clk_10m);
    abort = 0;
    start = 0;
    chk("abort_outputs", all_out, 0);
    repeat (3) @(negedge clk_10m);
    chk("abort_start_ignored", all_out, 0);
    chk("abort_scoreboard_empty", cq.size(), 0);
    // reset while SEND(READ) holds cmd_req and the encoder is slow to ack
    ack_dly = 10;
    cq.push_back('{0, 0, 1});
    cq.push_back('{1, 0, 2});
    cq.push_back('{2, 0, 32});
    cq.push_back('{3, 0, 32});
    outq.push_back('{0, 30});
    outq.push_back('{0, 30});
    pulse_start();
    k = 0;
    while (!(led_read && cif.cmd_req) && k < 1000) begin @(negedge clk_10m); k++; end
    chk("reach_send_read", int'(k < 1000), 1);
    rst_p = 1;
    @(negedge clk_10m);
    rst_p = 0;
    chk("midround_reset_outputs", all_out, 0);
    repeat (20) @(negedge clk_10m);
    chk("reset_idle_after_stray_ack", all_out, 0);
    chk("reset_scoreboard_empty", cq.size(), 0);
    ack_dly = 3;
    run_round(0);
    for (int i = 0; i < 8; i++) begin
      ack_dly = $urandom_range(1, 6);
      run_round(4);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
